// File: rtl/ex_mem_branch_commit_if.sv
// ex_mem_branch_commit_if
// Bundles the EX-stage instruction fields, the memory-stage stall, and the
// resulting EX/MEM register contents and front-end redirect/flush controls.
//   master : EX-side producer (drives ex_*, alu_out, branch_cond, stall)
//   slave  : the commit stage (consumes ex_*, drives mem_*, redirect_*, flush_*)
interface ex_mem_branch_commit_if;
    logic        stall;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_is_jal;
    logic        ex_is_jalr;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] alu_out;
    logic        branch_cond;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [31:0] ex_store_data;

    logic        mem_valid;
    logic [31:0] mem_alu_out;
    logic [31:0] mem_store_data;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic        mem_mem_read;
    logic        mem_mem_write;
    logic        mem_misaligned;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_if_id;
    logic        flush_id_ex;

    modport master (
        output stall, ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_pc, ex_imm,
               alu_out, branch_cond, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_store_data,
        input  mem_valid, mem_alu_out, mem_store_data, mem_rd, mem_reg_write,
               mem_mem_read, mem_mem_write, mem_misaligned, redirect_valid,
               redirect_pc, flush_if_id, flush_id_ex
    );

    modport slave (
        input  stall, ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_pc, ex_imm,
               alu_out, branch_cond, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_store_data,
        output mem_valid, mem_alu_out, mem_store_data, mem_rd, mem_reg_write,
               mem_mem_read, mem_mem_write, mem_misaligned, redirect_valid,
               redirect_pc, flush_if_id, flush_id_ex
    );
endinterface

// File: rtl/ex_mem_branch_commit.sv
// ex_mem_branch_commit
// EX/MEM pipeline register of the RV32I core. Resolves branches, JAL and JALR,
// issues a registered PC redirect with front-end flushes, and turns wrong-path
// instructions arriving during the redirect shadow into bubbles.
// Ports:
//   clk_i  : rising-edge clock
//   rst_i  : synchronous active-high reset
//   bus    : slave side of ex_mem_branch_commit_if (EX inputs, stall, MEM outputs,
//            redirect and flush controls); every output is a flop
//
// state  | meaning
// RUN    | capture EX into MEM, resolve control transfers
// SHADOW | EX holds wrong-path instructions; capture bubbles until count expires
module ex_mem_branch_commit #(
    parameter int unsigned SHADOW_CYCLES = 1,
    parameter int unsigned RESET_PC_LINK = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    ex_mem_branch_commit_if.slave   bus
);
    localparam int CW = (SHADOW_CYCLES < 2) ? 1 : $clog2(SHADOW_CYCLES + 1);

    typedef enum logic {RUN, SHADOW} state_t;

    state_t      state_q;
    logic [CW-1:0] cnt_q;

    logic        mem_valid_q;
    logic [31:0] mem_alu_out_q;
    logic [31:0] mem_store_data_q;
    logic [4:0]  mem_rd_q;
    logic        mem_reg_write_q;
    logic        mem_mem_read_q;
    logic        mem_mem_write_q;
    logic        mem_misaligned_q;
    logic        redirect_valid_q;
    logic [31:0] redirect_pc_q;
    logic        flush_q;

    logic        is_jump;
    logic        taken;
    logic        misaligned;
    logic [31:0] target;
    logic [31:0] link;

    always_comb begin
        is_jump    = bus.ex_is_jal | bus.ex_is_jalr;
        taken      = bus.ex_valid & (is_jump | (bus.ex_is_branch & bus.branch_cond));
        // JALR clears bit 0 of rs1+imm; branches and JAL are PC-relative
        target     = bus.ex_is_jalr ? (bus.alu_out & 32'hFFFF_FFFE) : (bus.ex_pc + bus.ex_imm);
        misaligned = taken & target[1];
        link       = bus.ex_pc + 32'(RESET_PC_LINK);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= RUN;
            cnt_q            <= '0;
            mem_valid_q      <= 1'b0;
            mem_alu_out_q    <= '0;
            mem_store_data_q <= '0;
            mem_rd_q         <= '0;
            mem_reg_write_q  <= 1'b0;
            mem_mem_read_q   <= 1'b0;
            mem_mem_write_q  <= 1'b0;
            mem_misaligned_q <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
        end else if (!bus.stall) begin
            // stall holds everything, which also stretches an active redirect pulse
            case (state_q)
                RUN: begin
                    mem_valid_q      <= bus.ex_valid;
                    mem_alu_out_q    <= is_jump ? link : bus.alu_out;
                    mem_store_data_q <= bus.ex_store_data;
                    mem_rd_q         <= bus.ex_rd;
                    // a misaligned jump must not write its link register
                    mem_reg_write_q  <= bus.ex_valid & bus.ex_reg_write & ~misaligned;
                    mem_mem_read_q   <= bus.ex_valid & bus.ex_mem_read;
                    mem_mem_write_q  <= bus.ex_valid & bus.ex_mem_write;
                    mem_misaligned_q <= misaligned;
                    if (taken && !misaligned) begin
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= target;
                        flush_q          <= 1'b1;
                        state_q          <= SHADOW;
                        cnt_q            <= CW'(SHADOW_CYCLES);
                    end else begin
                        redirect_valid_q <= 1'b0;
                        flush_q          <= 1'b0;
                    end
                end
                SHADOW: begin
                    mem_valid_q      <= 1'b0;
                    mem_alu_out_q    <= '0;
                    mem_store_data_q <= '0;
                    mem_rd_q         <= '0;
                    mem_reg_write_q  <= 1'b0;
                    mem_mem_read_q   <= 1'b0;
                    mem_mem_write_q  <= 1'b0;
                    mem_misaligned_q <= 1'b0;
                    redirect_valid_q <= 1'b0;
                    flush_q          <= 1'b0;
                    cnt_q            <= cnt_q - 1'b1;
                    if (cnt_q <= CW'(1)) begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign bus.mem_valid      = mem_valid_q;
    assign bus.mem_alu_out    = mem_alu_out_q;
    assign bus.mem_store_data = mem_store_data_q;
    assign bus.mem_rd         = mem_rd_q;
    assign bus.mem_reg_write  = mem_reg_write_q;
    assign bus.mem_mem_read   = mem_mem_read_q;
    assign bus.mem_mem_write  = mem_mem_write_q;
    assign bus.mem_misaligned = mem_misaligned_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.flush_if_id    = flush_q;
    assign bus.flush_id_ex    = flush_q;
endmodule

// File: doc/ex_mem_branch_commit.md
Name: ex_mem_branch_commit

Overview:
- Sits at the output of the EX stage of the pipelined RV32I core, downstream of the ALU, and acts as the EX/MEM pipeline register.
- Consumes the ALU result and branch condition, resolves control transfers (branches, JAL, JALR) and issues a registered PC redirect.
- Drives the front-end flushes and squashes wrong-path instructions that reach EX during the redirect shadow.
- Stalls as a whole when the memory stage is busy.

Parameters:
- SHADOW_CYCLES, 1: number of unstalled cycles after a redirect during which EX instructions are captured as bubbles.
- RESET_PC_LINK, 4: link offset added to ex_pc for JAL/JALR writeback.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- stall  in  1  memory stage busy; hold all state
- ex_valid  in  1  EX holds a real instruction
- ex_is_branch  in  1  conditional branch
- ex_is_jal  in  1  JAL
- ex_is_jalr  in  1  JALR
- ex_pc  in  32  PC of the EX instruction
- ex_imm  in  32  sign-extended immediate
- alu_out  in  32  ALU result (JALR: rs1+imm)
- branch_cond  in  1  ALU branch comparison result
- ex_rd  in  5  destination register
- ex_reg_write  in  1  writes rd
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_store_data  in  32  forwarded rs2
- mem_valid  out  1  MEM holds a real instruction
- mem_alu_out  out  32  address/result (JAL/JALR: link value)
- mem_store_data  out  32  registered store data
- mem_rd  out  5  registered rd
- mem_reg_write, mem_mem_read, mem_mem_write  out  1 each  registered controls, gated by validity
- mem_misaligned  out  1  instruction-address-misaligned flag for the MEM instruction
- redirect_valid  out  1  fetch must load redirect_pc
- redirect_pc  out  32  redirect target
- flush_if_id, flush_id_ex  out  1 each  clear the younger pipeline registers

Behaviour:
- Reset: single clock edge with rst=1. All outputs 0, FSM=RUN, shadow counter=0. A reset during SHADOW aborts the redirect.
- taken = ex_valid & (ex_is_jal | ex_is_jalr | (ex_is_branch & branch_cond)).
- Target calculation:
  - branch/JAL target = ex_pc + ex_imm, 32-bit wrap.
  - JALR target = alu_out & 32'hFFFF_FFFE.
  - misaligned = taken & target[1].
- stall=1 overrides everything except rst. All registers, the counter and the FSM state hold. redirect_valid and flush_* stay asserted if already asserted, so a pulse is stretched.
- RUN, unstalled edge:
  - Capture the EX fields into mem_*.
  - mem_valid = ex_valid. The mem_reg_write, mem_mem_read and mem_mem_write controls are ANDed with ex_valid.
  - mem_alu_out = ex_pc + RESET_PC_LINK for JAL/JALR, else alu_out.
- taken & !misaligned in RUN, unstalled:
  - Next cycle: redirect_valid=1, redirect_pc=target, flush_if_id=1, flush_id_ex=1.
  - FSM -> SHADOW, counter = SHADOW_CYCLES.
  - Latency: branch in EX at cycle T; redirect visible in cycle T+1.
- taken & misaligned:
  - No redirect. mem_misaligned=1 and mem_reg_write=0 for that instruction.
  - FSM stays RUN.
- SHADOW, unstalled edge:
  - Capture a bubble: mem_valid and all controls are 0, mem_misaligned=0; data fields are don't-care and are held at 0.
  - redirect_valid and flush_* drop to 0.
  - Counter decrements. At 1 -> 0, FSM -> RUN.
  - Taken in SHADOW is ignored because that instruction is wrong-path.
- A not-taken branch produces a normal MEM entry with mem_reg_write=0 (ex_reg_write is 0 for branches) and no redirect.
- Outputs are registered only; there is no combinational path from inputs to outputs.

Test Plan:
- Reset: rst=1 for one edge with inputs nonzero -> all outputs 0. First unstalled edge with ex_valid=1, alu_out=32'h10, ex_rd=5, ex_reg_write=1 -> mem_alu_out=32'h10, mem_rd=5, mem_valid=1.
- BEQ taken: ex_pc=32'h100, ex_imm=32'h20, branch_cond=1 -> next cycle redirect_valid=1, redirect_pc=32'h120, both flushes=1. The following EX instruction is captured with mem_valid=0. The instruction after it is captured normally.
- JALR: ex_pc=32'h200, alu_out=32'h305 -> redirect_pc=32'h304, mem_alu_out=32'h204, mem_reg_write=1.
- Misaligned JAL: ex_pc=32'h100, ex_imm=32'h6 -> redirect_valid=0, mem_misaligned=1, mem_reg_write=0.
- Stall mid-redirect: hold stall=1 for 3 cycles right after a taken branch -> redirect_valid and flush_* stay 1 for those 3 cycles, mem_* are unchanged, and the shadow bubble is inserted on the first unstalled edge.
- Reset in SHADOW: assert rst in the cycle redirect_valid=1 -> next cycle all outputs 0, FSM=RUN, and the next taken branch is honoured.
